// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared types and constants for the data-memory arbiter slice.
//   rd_own_e  : registered read-owner state (who gets next cycle's mem_rdata)
//   owner_e   : combinational owner of the memory port in the current cycle
//   STARVE_LIMIT_DEFAULT : default consecutive-denial limit for the aux port
//   STARVE_W  : width of the starvation counter and of its limit input
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 8;
    localparam int unsigned STARVE_W             = 8;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_CPU  = 2'd1,
        R_AUX  = 2'd2
    } rd_own_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_AUX  = 2'd2
    } owner_e;

endpackage : dmem_arbiter_pkg

// File: rtl/arb_starve_counter.sv
// -----------------------------------------------------------------------------
// arb_starve_counter
// Counts consecutive cycles in which the aux requester was denied the memory
// port. Saturates at 'limit'; 'clr' has priority over 'inc'.
// Only instantiated when DMEM_ARB_FAIRNESS_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : aux request pending and not granted this cycle
//   clr        : aux granted or not requesting this cycle
//   limit      : saturation value (1..255)
//   at_limit   : counter has reached 'limit' (forces an aux grant upstream)
// -----------------------------------------------------------------------------
module arb_starve_counter
    import dmem_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                clr,
    input  logic [STARVE_W-1:0] limit,
    output logic                at_limit
);

    logic [STARVE_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt < limit)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign at_limit = (r_cnt == limit);

endmodule : arb_starve_counter

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one synchronous-read data memory (1-cycle read latency) between the
// CPU EX-stage port and an auxiliary loader/debug port. The CPU normally wins;
// the aux transaction completes in the single cycle aux_gnt is high and its
// read data returns one cycle later with aux_rvalid.
//
// Build option: DMEM_ARB_FAIRNESS_EN
//   defined   : after STARVE_LIMIT consecutive denied aux cycles the aux port
//               is forced onto the memory and cpu_stall holds the CPU for that
//               cycle.
//   undefined : strict CPU priority, cpu_stall tied low, no counter.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata          CPU access request (EX stage)
//   cpu_stall                      CPU must hold PC and EX-stage signals
//   cpu_rdata                      CPU load data (WB stage), 0 when not a CPU read
//   aux_req/we/addr/wdata          aux access request, held until aux_gnt
//   aux_gnt                        aux owns the memory this cycle
//   aux_rvalid, aux_rdata          aux read data, one cycle after a read grant
//   mem_we/addr/wdata, mem_rdata   memory port (byte lanes 3..0)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_req,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,

    input  logic        aux_req,
    input  logic [3:0]  aux_we,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    output logic        aux_gnt,
    output logic        aux_rvalid,
    output logic [31:0] aux_rdata,

    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_limit_check
        $error("dmem_arbiter: STARVE_LIMIT must be in 1..255");
    end

    owner_e  w_owner;
    rd_own_e r_rd_own;
    rd_own_e w_rd_own_nxt;
    logic    w_force;

    // -------------------------------------------------------------------------
    // Aux starvation / forced grant
    // -------------------------------------------------------------------------
`ifdef DMEM_ARB_FAIRNESS_EN
    logic w_at_limit;
    logic w_starve_inc;
    logic w_starve_clr;

    assign w_starve_inc = aux_req & ~aux_gnt;
    assign w_starve_clr = aux_gnt | ~aux_req;

    arb_starve_counter u_starve_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (w_starve_inc),
        .clr      (w_starve_clr),
        .limit    (STARVE_W'(STARVE_LIMIT)),
        .at_limit (w_at_limit)
    );

    // rst_n gates the force so cpu_stall reads 0 while reset is held.
    assign w_force = rst_n & aux_req & w_at_limit;
`else
    assign w_force = 1'b0;
`endif

    assign cpu_stall = w_force;

    // -------------------------------------------------------------------------
    // Current-cycle owner. Reset forces NONE so every combinational output
    // (aux_gnt, mem_*) is 0 while rst_n is low.
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_owner = OWN_NONE;
        if (!rst_n) begin
            w_owner = OWN_NONE;
        end else if (cpu_req && !w_force) begin
            w_owner = OWN_CPU;
        end else if (aux_req) begin
            w_owner = OWN_AUX;
        end
    end

    assign aux_gnt = (w_owner == OWN_AUX);

    // -------------------------------------------------------------------------
    // Memory port mux; byte enables pass through unmodified.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_we    = 4'b0000;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        case (w_owner)
            OWN_CPU: begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            OWN_AUX: begin
                mem_we    = aux_we;
                mem_addr  = aux_addr;
                mem_wdata = aux_wdata;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Read-owner FSM: remembers who issued a read so the 1-cycle-late
    // mem_rdata is steered to the right requester. Writes load R_NONE.
    // -------------------------------------------------------------------------
    always_comb begin
        w_rd_own_nxt = R_NONE;
        case (w_owner)
            OWN_CPU: if (cpu_we == 4'b0000) w_rd_own_nxt = R_CPU;
            OWN_AUX: if (aux_we == 4'b0000) w_rd_own_nxt = R_AUX;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_own <= R_NONE;
        end else begin
            r_rd_own <= w_rd_own_nxt;
        end
    end

    assign cpu_rdata  = (r_rd_own == R_CPU) ? mem_rdata : 32'h0;
    assign aux_rvalid = (r_rd_own == R_AUX);
    assign aux_rdata  = aux_rvalid ? mem_rdata : 32'h0;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. Expected aux grants and aux read data are
// queued when stimulus is issued; a negedge monitor pops and compares whenever
// the DUT raises aux_gnt or aux_rvalid. The memory model returns
// 32'hD000_0000 ^ addr one cycle after the address is presented, so expected
// read data are hand-computed constants. Expectations follow the build:
// DMEM_ARB_FAIRNESS_EN selects forced-grant behaviour.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int LIMIT = 8;
`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
    } gnt_exp_t;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        aux_req;
    logic [3:0]  aux_we;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic        aux_gnt;
    logic        aux_rvalid;
    logic [31:0] aux_rdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    gnt_exp_t    gnt_q[$];
    logic [31:0] rv_q[$];

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .aux_req    (aux_req),
        .aux_we     (aux_we),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_gnt    (aux_gnt),
        .aux_rvalid (aux_rvalid),
        .aux_rdata  (aux_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory model.
    always @(posedge clk) mem_rdata <= 32'hD000_0000 ^ mem_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every aux_gnt / aux_rvalid must match the next queued expectation.
    always @(negedge clk) begin
        gnt_exp_t    eg;
        logic [31:0] er;
        if (aux_rvalid) begin
            if (rv_q.size() == 0) begin
                check("unexpected aux_rvalid", 32'(aux_rvalid), 32'd0);
            end else begin
                er = rv_q.pop_front();
                check("aux_rdata", aux_rdata, er);
            end
        end
        if (aux_gnt) begin
            if (gnt_q.size() == 0) begin
                check("unexpected aux_gnt", 32'(aux_gnt), 32'd0);
            end else begin
                eg = gnt_q.pop_front();
                check("gnt mem_addr",  mem_addr,          eg.addr);
                check("gnt mem_we",    32'(mem_we),       32'(eg.we));
                check("gnt mem_wdata", mem_wdata,         eg.wdata);
                check("gnt cpu_stall", 32'(cpu_stall),    32'(eg.stall));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req   = 1'b0;
        cpu_we    = 4'b0000;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        aux_req   = 1'b0;
        aux_we    = 4'b0000;
        aux_addr  = 32'h0;
        aux_wdata = 32'h0;
    endtask

    task automatic aux_issue(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        aux_req   = 1'b1;
        aux_we    = we;
        aux_addr  = addr;
        aux_wdata = wdata;
    endtask

    // CPU reads 0x20 every cycle while aux requests a read of 0x60.
    task automatic contend(input int n);
        for (int i = 0; i < n; i++) begin
            bit g;
            g         = FAIR && (i == LIMIT);
            cpu_req   = 1'b1;
            cpu_we    = 4'b0000;
            cpu_addr  = 32'h20;
            cpu_wdata = 32'h0;
            aux_issue(4'b0000, 32'h60, 32'h0);
            if (g) begin
                gnt_q.push_back('{we: 4'b0000, addr: 32'h60, wdata: 32'h0, stall: 1'b1});
                rv_q.push_back(32'hD000_0060);
            end
            @(negedge clk);
            check($sformatf("contend cpu_stall i=%0d", i), 32'(cpu_stall), 32'(g));
            check($sformatf("contend aux_gnt i=%0d", i),   32'(aux_gnt),   32'(g));
            check($sformatf("contend mem_addr i=%0d", i),  mem_addr, g ? 32'h60 : 32'h20);
            tick();
            if (g) break;
        end
    endtask

    initial begin
        // ---------------- reset with both requesters active ----------------
        rst_n     = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 4'hF;
        cpu_addr  = 32'h1234;
        cpu_wdata = 32'h5555_AAAA;
        aux_issue(4'b0000, 32'h55, 32'h0);
        repeat (2) @(negedge clk);
        check("reset cpu_stall",  32'(cpu_stall),  32'd0);
        check("reset aux_gnt",    32'(aux_gnt),    32'd0);
        check("reset aux_rvalid", 32'(aux_rvalid), 32'd0);
        check("reset mem_we",     32'(mem_we),     32'd0);
        check("reset mem_addr",   mem_addr,        32'd0);
        check("reset cpu_rdata",  cpu_rdata,       32'd0);
        tick();
        rst_n = 1'b1;
        idle_inputs();

        // ---------------- CPU-only read of 0x10 ----------------
        cpu_req  = 1'b1;
        cpu_addr = 32'h10;
        @(negedge clk);
        check("cpu rd mem_addr", mem_addr,     32'h10);
        check("cpu rd mem_we",   32'(mem_we),  32'd0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("cpu rd cpu_rdata",  cpu_rdata,        32'hD000_0010);
        check("cpu rd aux_rvalid", 32'(aux_rvalid),  32'd0);
        check("idle mem_addr",     mem_addr,         32'd0);
        check("idle mem_we",       32'(mem_we),      32'd0);
        tick();
        @(negedge clk);
        check("after idle cpu_rdata", cpu_rdata, 32'd0);

        // ---------------- CPU write: byte enables, no read data ----------------
        tick();
        cpu_req   = 1'b1;
        cpu_we    = 4'b1001;
        cpu_addr  = 32'h14;
        cpu_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("cpu wr mem_we",    32'(mem_we), 32'b1001);
        check("cpu wr mem_wdata", mem_wdata,   32'hCAFE_F00D);
        tick();
        idle_inputs();
        @(negedge clk);
        check("cpu wr no cpu_rdata", cpu_rdata, 32'd0);

        // ---------------- aux-only read of 0x40 ----------------
        tick();
        gnt_q.push_back('{we: 4'b0000, addr: 32'h40, wdata: 32'h0, stall: 1'b0});
        rv_q.push_back(32'hD000_0040);
        aux_issue(4'b0000, 32'h40, 32'h0);
        @(negedge clk);
        check("aux rd gnt same cycle", 32'(aux_gnt), 32'd1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("aux rd rvalid next cycle", 32'(aux_rvalid), 32'd1);
        check("aux rd no cpu_rdata",      cpu_rdata,       32'd0);

        // ---------------- aux write ----------------
        tick();
        gnt_q.push_back('{we: 4'b0010, addr: 32'h80, wdata: 32'h0000_AB00, stall: 1'b0});
        aux_issue(4'b0010, 32'h80, 32'h0000_AB00);
        @(negedge clk);
        tick();
        idle_inputs();
        @(negedge clk);
        check("aux wr mem_we one cycle", 32'(mem_we),     32'd0);
        check("aux wr no rvalid",        32'(aux_rvalid), 32'd0);

        // ---------------- contention / starvation ----------------
        tick();
        contend(5);
        // aux drops for one cycle: the starvation count must restart
        aux_req = 1'b0;
        @(negedge clk);
        check("gap cpu_stall", 32'(cpu_stall), 32'd0);
        check("gap mem_addr",  mem_addr,       32'h20);
        tick();
        contend(12);
        aux_req = 1'b0;
        @(negedge clk);
        check("post-contend cpu_stall", 32'(cpu_stall), 32'd0);
        tick();
        // counter must be back at zero: a short burst gets no grant
        contend(4);
        idle_inputs();

        // ---------------- reset right after an aux read grant ----------------
        gnt_q.push_back('{we: 4'b0000, addr: 32'h44, wdata: 32'h0, stall: 1'b0});
        aux_issue(4'b0000, 32'h44, 32'h0);
        @(negedge clk);
        tick();
        rst_n     = 1'b0;
        aux_issue(4'b0000, 32'h48, 32'h0);
        cpu_req   = 1'b1;
        cpu_addr  = 32'h30;
        @(negedge clk);
        check("rst-after-gnt aux_rvalid", 32'(aux_rvalid),   32'd0);
        check("rst-after-gnt aux_rdata",  aux_rdata,         32'd0);
        check("rst-after-gnt rd_own",     32'(dut.r_rd_own), 32'(R_NONE));
        check("rst-after-gnt aux_gnt",    32'(aux_gnt),      32'd0);
        check("rst-after-gnt cpu_stall",  32'(cpu_stall),    32'd0);
        check("rst-after-gnt mem_we",     32'(mem_we),       32'd0);
        check("rst-after-gnt mem_addr",   mem_addr,          32'd0);
        check("rst-after-gnt cpu_rdata",  cpu_rdata,         32'd0);
        tick();
        rst_n = 1'b1;
        idle_inputs();
        // reissue the lost read
        gnt_q.push_back('{we: 4'b0000, addr: 32'h44, wdata: 32'h0, stall: 1'b0});
        rv_q.push_back(32'hD000_0044);
        aux_issue(4'b0000, 32'h44, 32'h0);
        @(negedge clk);
        tick();
        idle_inputs();
        repeat (3) tick();
        @(negedge clk);

        check("all grants seen",   32'(gnt_q.size()), 32'd0);
        check("all rvalids seen",  32'(rv_q.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmem_arbiter
